// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous upstream FIFO (one-cycle read latency)
// into a valid/ready stream through a 4-entry skid buffer. Reads are only
// issued when a buffer slot is guaranteed for the returning word, so the
// read request never depends on m_ready.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  idle,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
);

   logic [2:0]            occ_q, occ_d;
   logic                  infl_q, infl_d;
   logic [1:0]            wptr_q, wptr_d;
   logic [1:0]            rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] buf_q [4];

   logic [3:0]            fill;
   logic                  xfer;

   // Read request and stream outputs, derived from registered state only
   always_comb begin
      fill       = {1'b0, occ_q} + {3'b000, infl_q};
      fifo_rd_en = en && !fifo_empty && (fill < 4'd4);
      m_valid    = (occ_q != 3'd0);
      m_data     = m_valid ? buf_q[rptr_q] : '0;
      idle       = (occ_q == 3'd0) && !infl_q;
      xfer_cnt   = cnt_q;
      xfer       = m_valid && m_ready;
   end

   // Next-state for pointers, occupancy, in-flight flag and transfer count
   always_comb begin
      infl_d = fifo_rd_en;
      wptr_d = infl_q ? wptr_q + 2'd1 : wptr_q;
      rptr_d = xfer   ? rptr_q + 2'd1 : rptr_q;
      cnt_d  = xfer   ? cnt_q + CNT_WIDTH'(1) : cnt_q;
      occ_d  = occ_q + {2'b00, infl_q} - {2'b00, xfer};
   end

   // Control state with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= '0;
         infl_q <= 1'b0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         occ_q  <= occ_d;
         infl_q <= infl_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Buffer storage: captures the word returned one cycle after a read
   always_ff @(posedge clk) begin
      if (infl_q) begin
         buf_q[wptr_q] <= fifo_data;
      end
   end

endmodule
